// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables and helpers, S-boxes, key shift schedules and FSM state encoding
package des_pkg;
  typedef enum logic [1:0] {IDLE, CRYPT, DONE} state_t;
  localparam int IP_T [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                               62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                               57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                               61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                               38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                               36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                               34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                              16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHL [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SHR [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7, 0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0, 15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10, 3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15, 13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7, 1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15, 13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4, 3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9, 14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14, 11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11, 10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6, 4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1, 13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2, 6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7, 1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8, 2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
  function automatic logic [0:63] ip(input logic [0:63] d);
    for (int i = 0; i < 64; i++) ip[i] = d[6'(IP_T[i] - 1)];
  endfunction
  function automatic logic [0:63] fp(input logic [0:63] d);
    for (int i = 0; i < 64; i++) fp[i] = d[6'(FP_T[i] - 1)];
  endfunction
  function automatic logic [0:47] e(input logic [0:31] d);
    for (int i = 0; i < 48; i++) e[i] = d[5'(E_T[i] - 1)];
  endfunction
  function automatic logic [0:31] p(input logic [0:31] d);
    for (int i = 0; i < 32; i++) p[i] = d[5'(P_T[i] - 1)];
  endfunction
  function automatic logic [0:55] pc1(input logic [0:63] k);
    for (int i = 0; i < 56; i++) pc1[i] = k[6'(PC1_T[i] - 1)];
  endfunction
  function automatic logic [0:47] pc2(input logic [0:55] k);
    for (int i = 0; i < 48; i++) pc2[i] = k[6'(PC2_T[i] - 1)];
  endfunction
  // Rotates C and D halves for round g: left for encrypt, right (mirrored schedule) for decrypt.
  function automatic logic [0:55] rot(input logic [0:55] k, input logic dec, input logic [3:0] g);
    logic [27:0] c, d;
    int s;
    s = dec ? SHR[g] : SHL[g];
    c = k[0:27];
    d = k[28:55];
    return dec ? {(c >> s) | (c << (28 - s)), (d >> s) | (d << (28 - s))}
               : {(c << s) | (c >> (28 - s)), (d << s) | (d >> (28 - s))};
  endfunction
endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES Feistel round
// Ports: l, r - round input halves; k - 48-bit subkey; l_n, r_n - round output halves.
module des_round
  import des_pkg::*;
(
  input  logic [0:31] l,
  input  logic [0:31] r,
  input  logic [0:47] k,
  output logic [0:31] l_n,
  output logic [0:31] r_n
);
  logic [0:47] x;
  logic [0:5]  b;
  logic [0:31] s;
  always_comb begin
    x = e(r) ^ k;
    s = '0;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[6*i +: 6];
      s[4*i +: 4] = 4'(SBOX[i][{b[0], b[5], b[1:4]}]);
    end
  end
  assign l_n = r;
  assign r_n = l ^ p(s);
endmodule

// File: rtl/des_iter.sv
// des_iter: iterative DES core, UNROLL rounds per clock, optional TDES under DES_ITER_TDES_EN
// Ports: clk_i/reset_i (async active-low); mode_i 0=encrypt 1=decrypt; key_i, data_i, valid_i
// with accept_o handshake in; data_o, valid_o with accept_i handshake out.
// DES_ITER_TDES_EN adds tdes_i, key2_i, key3_i for three back-to-back passes.
module des_iter
  import des_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mode_i,
  input  logic [0:63] key_i,
  input  logic [0:63] data_i,
  input  logic        valid_i,
  output logic        accept_o,
  output logic [0:63] data_o,
  output logic        valid_o,
  input  logic        accept_i
`ifdef DES_ITER_TDES_EN
  ,
  input  logic        tdes_i,
  input  logic [0:63] key2_i,
  input  logic [0:63] key3_i
`endif
);
  localparam int CYC = 16 / UNROLL;
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) begin : g_bad_unroll
    $error("des_iter: UNROLL must be 1, 2, 4, 8 or 16");
  end
  state_t      state;
  logic [0:31] l, r;
  logic [0:55] key;
  logic        dec;
  logic [4:0]  cnt;
  logic [0:31] lc [UNROLL+1];
  logic [0:31] rc [UNROLL+1];
  logic [0:55] kc [UNROLL+1];
`ifdef DES_ITER_TDES_EN
  logic        tdes;
  logic [1:0]  pass;
  logic [0:55] key2, key_x;
`endif
  assign lc[0] = l;
  assign rc[0] = r;
  assign kc[0] = key;
  // cnt counts round-cycles left, so rounds already done = 16 - cnt*UNROLL (mod 16).
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    assign kc[j+1] = rot(kc[j], dec, 4'(j - int'(cnt) * UNROLL));
    des_round u_round (
      .l(lc[j]),
      .r(rc[j]),
      .k(pc2(kc[j+1])),
      .l_n(lc[j+1]),
      .r_n(rc[j+1])
    );
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state    <= IDLE;
      accept_o <= 1'b1;
      valid_o  <= 1'b0;
      data_o   <= '0;
      l        <= '0;
      r        <= '0;
      key      <= '0;
      dec      <= 1'b0;
      cnt      <= '0;
`ifdef DES_ITER_TDES_EN
      tdes     <= 1'b0;
      pass     <= '0;
      key2     <= '0;
      key_x    <= '0;
`endif
    end else
      case (state)
        IDLE:
          if (valid_i && accept_o) begin
            {l, r}   <= ip(data_i);
            dec      <= mode_i;
            cnt      <= 5'(CYC);
            accept_o <= 1'b0;
            state    <= CRYPT;
`ifdef DES_ITER_TDES_EN
            key      <= pc1(tdes_i && mode_i ? key3_i : key_i);
            tdes     <= tdes_i;
            pass     <= '0;
            key2     <= pc1(key2_i);
            // Key of the third pass: k3 when encrypting, k1 when decrypting.
            key_x    <= pc1(mode_i ? key_i : key3_i);
`else
            key      <= pc1(key_i);
`endif
          end
        CRYPT:
          if (cnt == 5'd0) begin
            data_o  <= fp({r, l});
            valid_o <= 1'b1;
            state   <= DONE;
          end
`ifdef DES_ITER_TDES_EN
          // FP then IP cancel between passes, leaving only the final half swap.
          else if (tdes && cnt == 5'd1 && pass != 2'd2) begin
            l    <= rc[UNROLL];
            r    <= lc[UNROLL];
            key  <= pass == 2'd0 ? key2 : key_x;
            dec  <= ~dec;
            pass <= pass + 2'd1;
            cnt  <= 5'(CYC);
          end
`endif
          else begin
            l   <= lc[UNROLL];
            r   <= rc[UNROLL];
            key <= kc[UNROLL];
            cnt <= cnt - 5'd1;
          end
        DONE:
          if (accept_i) begin
            valid_o  <= 1'b0;
            accept_o <= 1'b1;
            state    <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_des_iter.sv
// tb_des_iter: directed scoreboard bench driving five des_iter instances (UNROLL 1..16) in lockstep
module tb_des_iter;
  localparam logic [63:0] K = 64'h133457799BBCDFF1;
  localparam logic [63:0] P = 64'h0123456789ABCDEF;
  localparam logic [63:0] C = 64'h85E813540F0AB405;
  typedef struct {
    logic [63:0] v;
    bit          known;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic [63:0] key = '0;
  logic [63:0] data = '0;
  logic        valid = 1'b0;
  logic        accept = 1'b0;
  logic        acc [5];
  logic [0:63] dout [5];
  logic        vo [5];
`ifdef DES_ITER_TDES_EN
  logic        tdes = 1'b0;
  logic [63:0] key2 = '0;
  logic [63:0] key3 = '0;
`endif
  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q [$];
  logic [63:0] got, rk, rd;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_iter #(.UNROLL(1 << g)) dut (
      .clk_i(clk),
      .reset_i(reset),
      .mode_i(mode),
      .key_i(key),
      .data_i(data),
      .valid_i(valid),
      .accept_o(acc[g]),
      .data_o(dout[g]),
      .valid_o(vo[g]),
      .accept_i(accept)
`ifdef DES_ITER_TDES_EN
      ,
      .tdes_i(tdes),
      .key2_i(key2),
      .key3_i(key3)
`endif
    );
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic m, input logic [63:0] k, input logic [63:0] d, input logic [63:0] ev, input bit known);
    mode  = m;
    key   = k;
    data  = d;
    valid = 1'b1;
    exp_q.push_back('{ev, known});
    @(negedge clk);
    valid = 1'b0;
    mode  = ~m;
    key   = ~k;
    data  = ~d;
  endtask
  task automatic collect(input string tag, input int passes, input int hold, output logic [63:0] res);
    int   first [5];
    exp_t e;
    for (int u = 0; u < 5; u++) first[u] = 0;
    for (int n = 1; n <= 60 && first[0] == 0; n++) begin
      @(negedge clk);
      for (int u = 0; u < 5; u++) if (first[u] == 0 && vo[u]) first[u] = n;
    end
    e = exp_q.pop_front();
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("%s latency u%0d", tag, 1 << u), 64'(first[u]), 64'(passes * (16 >> u) + 1));
      if (e.known) chk($sformatf("%s data u%0d", tag, 1 << u), dout[u], e.v);
    end
    res = dout[0];
    for (int h = 0; h < hold; h++) begin
      valid = (h == 3);
      data  = ~data;
      @(negedge clk);
      chk($sformatf("%s hold valid %0d", tag, h), 64'(vo[0]), 64'd1);
      chk($sformatf("%s hold data %0d", tag, h), dout[0], e.v);
      chk($sformatf("%s hold accept %0d", tag, h), 64'(acc[0]), 64'd0);
    end
    valid  = 1'b0;
    accept = 1'b1;
    @(negedge clk);
    accept = 1'b0;
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("%s cleared valid u%0d", tag, 1 << u), 64'(vo[u]), 64'd0);
      chk($sformatf("%s accept back u%0d", tag, 1 << u), 64'(acc[u]), 64'd1);
    end
    if (e.known) chk($sformatf("%s data kept", tag), dout[0], e.v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("reset accept u%0d", 1 << u), 64'(acc[u]), 64'd1);
      chk($sformatf("reset valid u%0d", 1 << u), 64'(vo[u]), 64'd0);
      chk($sformatf("reset data u%0d", 1 << u), dout[u], 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    send(1'b0, K, P, C, 1'b1);
    collect("enc", 1, 0, got);
    send(1'b1, K, C, P, 1'b1);
    collect("dec", 1, 0, got);
    send(1'b0, 64'h0123456789ABCDEF, 64'h4E6F772069732074, 64'h3FA40E8A984D4815, 1'b1);
    collect("now", 1, 0, got);
    send(1'b0, 64'h0E329232EA6D0D73, 64'h8787878787878787, 64'h0, 1'b1);
    collect("zero", 1, 0, got);
    for (int i = 0; i < 2; i++) begin
      rk = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      send(1'b0, rk, rd, 64'h0, 1'b0);
      collect("trip enc", 1, 0, got);
      send(1'b1, rk, got, rd, 1'b1);
      collect("trip dec", 1, 0, got);
    end
    accept = 1'b1;
    repeat (2) @(negedge clk);
    accept = 1'b0;
    chk("idle accept_i accept_o", 64'(acc[0]), 64'd1);
    chk("idle accept_i valid_o", 64'(vo[0]), 64'd0);
    send(1'b0, K, P, C, 1'b1);
    collect("hold", 1, 10, got);
    repeat (20) @(negedge clk);
    chk("after hold valid_o", 64'(vo[0]), 64'd0);
    chk("after hold accept_o", 64'(acc[0]), 64'd1);
    send(1'b0, K, P, C, 1'b1);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("mid reset valid u%0d", 1 << u), 64'(vo[u]), 64'd0);
      chk($sformatf("mid reset data u%0d", 1 << u), dout[u], 64'd0);
      chk($sformatf("mid reset accept u%0d", 1 << u), 64'(acc[u]), 64'd1);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(1'b1, K, C, P, 1'b1);
    collect("after reset", 1, 0, got);
`ifdef DES_ITER_TDES_EN
    tdes = 1'b1;
    key2 = K;
    key3 = K;
    send(1'b0, K, P, C, 1'b1);
    collect("tdes same keys", 3, 0, got);
    key2 = 64'h23456789ABCDEF01;
    key3 = 64'h456789ABCDEF0123;
    send(1'b0, 64'h0123456789ABCDEF, P, 64'h0, 1'b0);
    collect("tdes enc", 3, 0, got);
    key2 = 64'h23456789ABCDEF01;
    key3 = 64'h456789ABCDEF0123;
    send(1'b1, 64'h0123456789ABCDEF, got, P, 1'b1);
    collect("tdes dec", 3, 0, got);
    tdes = 1'b0;
    send(1'b1, K, C, P, 1'b1);
    collect("tdes off", 1, 0, got);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/des_iter.md
DES_ITER -- requirements
Module: des_iter

Interface
REQ-001 SHALL have parameter UNROLL, default 1, giving DES rounds computed per clock; legal values are 1, 2, 4, 8 and 16.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port mode_i, input, 1 bit: 0 selects encrypt, 1 selects decrypt; sampled at load.
REQ-005 SHALL have port key_i, input, [0:63]: key in FIPS 46-3 bit order; parity bits are ignored.
REQ-006 SHALL have port data_i, input, [0:63]: plaintext or ciphertext block.
REQ-007 SHALL have port valid_i, input, 1 bit: input block valid.
REQ-008 SHALL have port accept_o, output, 1 bit: core can take an input block.
REQ-009 SHALL have port data_o, output, [0:63]: result block.
REQ-010 SHALL have port valid_o, output, 1 bit: data_o valid.
REQ-011 SHALL have port accept_i, input, 1 bit: downstream takes the result.

Function
REQ-012 SHALL implement an FSM with states IDLE, CRYPT and DONE.
REQ-013 SHALL drive accept_o=1 only in IDLE.
REQ-014 SHALL load on valid_i & accept_o: register the IP-permuted data, the PC1-permuted key and the mode, then go to CRYPT.
REQ-015 SHALL, in CRYPT, perform UNROLL rounds per cycle for 16/UNROLL cycles using a round counter that counts down to 0.
REQ-016 SHALL use the standard left-shift schedule (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1) for encrypt, and for decrypt the mirrored right-shift schedule (0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
REQ-017 SHALL, after the last round, register FP(R16||L16) into data_o, set valid_o=1 and go to DONE.
REQ-018 SHALL place the rising edge of valid_o exactly 16/UNROLL+1 clocks after the load edge.
REQ-019 SHALL, in DONE, hold data_o and valid_o stable while accept_i=0.
REQ-020 SHALL, in DONE with accept_i=1, clear valid_o and return to IDLE; data_o keeps its last value.
REQ-021 SHALL ignore valid_i and all input ports outside IDLE.
REQ-022 SHALL drop an accept_i asserted while valid_o=0 without effect.

Reset
REQ-023 SHALL, while reset_i=0, immediately put the FSM in IDLE, drive accept_o=1 and drive valid_o=0 and data_o=0.
REQ-024 SHALL clear the round counter and internal data and key registers to 0 on reset.
REQ-025 SHALL, when reset asserts mid-CRYPT or mid-DONE, discard the block with no output produced.

Configuration
REQ-026 SHALL, with macro DES_ITER_TDES_EN defined, add inputs tdes_i (1 bit), key2_i [0:63] and key3_i [0:63], all sampled at load.
REQ-027 SHALL, when tdes_i=1, encrypt as E(k3,D(k2,E(k1,x))) and decrypt as D(k1,E(k2,D(k3,x))).
REQ-028 SHALL run the three TDES passes back-to-back in CRYPT with no IP/FP between passes, using a 2-bit pass counter and reloading the key register from the pass's key.
REQ-029 SHALL give TDES a latency of 3*16/UNROLL+1 clocks.
REQ-030 SHALL, with tdes_i=0, behave exactly as single DES.
REQ-031 SHALL, without DES_ITER_TDES_EN, omit these ports and the pass logic entirely.

Structure
REQ-032 SHALL place IP, FP, E, P, PC1 and PC2 permutation functions, the eight S-box tables, the shift-schedule constant and the state encoding in the shared des_pkg package.
REQ-033 SHALL implement one Feistel round in sub-module des_round (inputs L, R, 48-bit subkey; outputs L', R'), instantiated UNROLL times in a generate chain.
REQ-034 SHALL implement key rotation in des_iter, not in des_round.
REQ-035 SHALL reject illegal UNROLL values at elaboration.

Verification
REQ-036 Bench SHALL cover: UNROLL=1, encrypt, key 133457799BBCDFF1, data 0123456789ABCDEF -> data_o 85E813540F0AB405 with valid_o rising 17 clocks after load.
REQ-037 Bench SHALL cover: the same vector with decrypt -> 0123456789ABCDEF, repeated for UNROLL=2, 4, 8 and 16 with latencies 9, 5, 3 and 2.
REQ-038 Bench SHALL cover: accept_i held 0 for 10 cycles after valid_o -> data_o and valid_o stable, accept_o=0, and a valid_i pulse in that window ignored.
REQ-039 Bench SHALL cover: reset_i pulsed low at round 7 -> valid_o=0, data_o=0, accept_o=1 immediately, and the next block computed correctly.
REQ-040 Bench SHALL cover, with DES_ITER_TDES_EN: k1=k2=k3=133457799BBCDFF1, tdes_i=1 -> 85E813540F0AB405 after 49 clocks (UNROLL=1); keys 0123456789ABCDEF/23456789ABCDEF01/456789ABCDEF0123 give an encrypt/decrypt round-trip identity.
